// File: rtl/aes_job_arbiter_if.sv
// Job-request, AES core and result signals shared between aes_job_arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the requester/core/consumer side.
interface aes_job_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 128,
  parameter int KSEL_W = 2
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*DATA_W-1:0] req_pt_i;
  logic [N_REQ*DATA_W-1:0] req_state_i;
  logic [N_REQ*KSEL_W-1:0] req_ksel_i;
  logic                    lock_i;

  logic [DATA_W-1:0]       core_pt_o;
  logic [DATA_W-1:0]       core_state_o;
  logic [KSEL_W-1:0]       core_ksel_o;
  logic                    core_start_o;
  logic [DATA_W-1:0]       core_ct_i;
  logic                    core_valid_i;

  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [ID_W-1:0]         rsp_id_o;
  logic [DATA_W-1:0]       rsp_ct_o;
  logic                    rsp_timeout_o;
  logic                    busy_o;

  modport slave (
    input  req_valid_i, req_pt_i, req_state_i, req_ksel_i, lock_i,
    input  core_ct_i, core_valid_i, rsp_ready_i,
    output req_ready_o, core_pt_o, core_state_o, core_ksel_o, core_start_o,
    output rsp_valid_o, rsp_id_o, rsp_ct_o, rsp_timeout_o, busy_o
  );

  modport master (
    output req_valid_i, req_pt_i, req_state_i, req_ksel_i, lock_i,
    output core_ct_i, core_valid_i, rsp_ready_i,
    input  req_ready_o, core_pt_o, core_state_o, core_ksel_o, core_start_o,
    input  rsp_valid_o, rsp_id_o, rsp_ct_o, rsp_timeout_o, busy_o
  );
endinterface

// File: rtl/aes_job_arbiter.sv
// Round-robin job scheduler sharing one AES-192 core between N_REQ requesters,
// with a watchdog that aborts jobs whose core result never arrives.
module aes_job_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 128,
  parameter int KSEL_W  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  aes_job_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HI, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   cand;
  logic              gnt_found;
  logic              grant;
  logic [TMR_W-1:0]  timer_q;
  logic              waiting;
  logic              done_hit;
  logic              tmo_hit;

  // First requesting index at or after rr_ptr_q, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!gnt_found && bus.req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign grant    = (state_q == IDLE) && !bus.lock_i && gnt_found;
  assign waiting  = (state_q == WAIT_LOW) || (state_q == WAIT_HI);
  assign done_hit = (state_q == WAIT_HI) && bus.core_valid_i;
  // A completion in the last allowed cycle takes priority over the abort.
  assign tmo_hit  = waiting && (timer_q == TMR_W'(TIMEOUT - 1)) && !done_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.req_ready_o  = '0;
    bus.core_start_o = 1'b0;
    bus.rsp_valid_o  = 1'b0;
    bus.busy_o       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (grant) begin
          bus.req_ready_o[gnt_id] = 1'b1;
          state_d                 = START;
        end
      end
      START: begin
        bus.core_start_o = 1'b1;
        state_d          = WAIT_LOW;
      end
      // A valid still high from the previous job must drop before a new result counts.
      WAIT_LOW: begin
        if (tmo_hit)                 state_d = RESP;
        else if (!bus.core_valid_i)  state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (done_hit || tmo_hit) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q          <= '0;
      timer_q           <= '0;
      bus.core_pt_o     <= '0;
      bus.core_state_o  <= '0;
      bus.core_ksel_o   <= '0;
      bus.rsp_id_o      <= '0;
      bus.rsp_ct_o      <= '0;
      bus.rsp_timeout_o <= 1'b0;
    end else begin
      if (grant) begin
        bus.core_pt_o    <= bus.req_pt_i[gnt_id*DATA_W +: DATA_W];
        bus.core_state_o <= bus.req_state_i[gnt_id*DATA_W +: DATA_W];
        bus.core_ksel_o  <= bus.req_ksel_i[gnt_id*KSEL_W +: KSEL_W];
        bus.rsp_id_o     <= gnt_id;
        rr_ptr_q         <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (state_q == START)              timer_q <= '0;
      else if (waiting && timer_q != '1) timer_q <= timer_q + 1'b1;
      if (done_hit) begin
        bus.rsp_ct_o      <= bus.core_ct_i;
        bus.rsp_timeout_o <= 1'b0;
      end else if (tmo_hit) begin
        bus.rsp_ct_o      <= '0;
        bus.rsp_timeout_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter: a behavioural AES core with programmable latency
// answers each start; expected results come from the requester operands.
module tb_aes_job_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int KW = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int   core_delay = 3;
  bit   core_hang  = 1'b0;
  int   cnt = 0;

  logic [DW-1:0] pt_v [N];
  logic [DW-1:0] st_v [N];
  logic [KW-1:0] ks_v [N];

  aes_job_arbiter_if #(.N_REQ(N), .DATA_W(DW), .KSEL_W(KW)) ifc ();

  aes_job_arbiter #(.N_REQ(N), .DATA_W(DW), .KSEL_W(KW), .TIMEOUT(64)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifc)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] p, input logic [DW-1:0] s,
                                            input logic [KW-1:0] k);
    return (p ^ {s[63:0], s[127:64]}) + DW'(k);
  endfunction

  // Behavioural core: a stale valid lingers through the first wait cycle, then drops;
  // the new result appears core_delay cycles after the start cycle.
  always @(posedge clk_i) begin
    #1;
    if (rst_i) begin
      ifc.core_valid_i = 1'b0;
      ifc.core_ct_i    = '0;
      cnt              = 0;
    end else if (ifc.core_start_o) begin
      cnt = core_delay;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == core_delay - 2) ifc.core_valid_i = 1'b0;
      if (cnt == 0 && !core_hang) begin
        ifc.core_valid_i = 1'b1;
        ifc.core_ct_i    = core_fn(ifc.core_pt_o, ifc.core_state_o, ifc.core_ksel_o);
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Called in an IDLE cycle with req_valid_i already driven; returns in the IDLE cycle
  // after the response handshake.
  task automatic run_job(input int id, input int delay, input int hold);
    int n;
    bit stable;
    logic [DW-1:0] ct_snap;
    core_delay = delay;
    core_hang  = 1'b0;
    #1;
    chk("ready_onehot", DW'(ifc.req_ready_o), DW'(1 << id));
    step();
    chk("start_hi", DW'(ifc.core_start_o), 1);
    chk("core_pt", ifc.core_pt_o, pt_v[id]);
    chk("core_state", ifc.core_state_o, st_v[id]);
    chk("core_ksel", DW'(ifc.core_ksel_o), DW'(ks_v[id]));
    step();
    chk("start_pulse", DW'(ifc.core_start_o), 0);
    n = 1;
    while (!ifc.rsp_valid_o && n < 200) begin
      step();
      n++;
    end
    chk("latency", DW'(n), DW'(delay + 1));
    chk("rsp_id", DW'(ifc.rsp_id_o), DW'(id));
    chk("rsp_ct", ifc.rsp_ct_o, core_fn(pt_v[id], st_v[id], ks_v[id]));
    chk("rsp_tmo", DW'(ifc.rsp_timeout_o), 0);
    chk("no_grant_resp", DW'(ifc.req_ready_o), 0);
    if (hold > 0) begin
      stable  = 1'b1;
      ct_snap = ifc.rsp_ct_o;
      for (int h = 0; h < hold; h++) begin
        step();
        if (!ifc.rsp_valid_o || ifc.rsp_ct_o !== ct_snap || ifc.rsp_id_o !== id[1:0] ||
            ifc.req_ready_o !== '0) stable = 1'b0;
      end
      chk("rsp_hold_stable", DW'(stable), 1);
    end
    ifc.rsp_ready_i = 1'b1;
    step();
    ifc.rsp_ready_i = 1'b0;
    chk("rsp_drop", DW'(ifc.rsp_valid_o), 0);
  endtask

  initial begin
    int quiet;
    pt_v[0] = 128'h00112233445566778899aabbccddeeff;
    pt_v[1] = 128'hdeadbeef0123456789abcdeffedcba98;
    pt_v[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    pt_v[3] = 128'hcafef00d5555aaaa12345678a5a5a5a5;
    st_v[0] = 128'h000102030405060708090a0b0c0d0e0f;
    st_v[1] = 128'hffeeddccbbaa99887766554433221100;
    st_v[2] = 128'h13579bdf2468ace013579bdf2468ace0;
    st_v[3] = 128'h8000000000000001c000000000000003;
    ks_v[0] = 2'd1; ks_v[1] = 2'd2; ks_v[2] = 2'd0; ks_v[3] = 2'd2;
    ifc.req_valid_i  = '0;
    ifc.lock_i       = 1'b0;
    ifc.rsp_ready_i  = 1'b0;
    ifc.core_valid_i = 1'b0;
    ifc.core_ct_i    = '0;
    for (int i = 0; i < N; i++) begin
      ifc.req_pt_i[i*DW +: DW]    = pt_v[i];
      ifc.req_state_i[i*DW +: DW] = st_v[i];
      ifc.req_ksel_i[i*KW +: KW]  = ks_v[i];
    end

    // Reset state
    #1;
    chk("rst_busy", DW'(ifc.busy_o), 0);
    chk("rst_rsp_valid", DW'(ifc.rsp_valid_o), 0);
    chk("rst_core_pt", ifc.core_pt_o, 0);
    chk("rst_start", DW'(ifc.core_start_o), 0);
    step(); step();
    rst_i = 1'b0;
    step();

    // Single job from requester 0, core answers 6 cycles after start
    ifc.req_valid_i = 4'b0001;
    run_job(0, 6, 0);
    ifc.req_valid_i = 4'b0000;

    // Fresh reset, then all four requesting: strict rotation
    rst_i = 1'b1; step(); rst_i = 1'b0; step();
    ifc.req_valid_i = 4'b1111;
    for (int j = 0; j < 8; j++) run_job(j % 4, 3 + j, 0);
    ifc.req_valid_i = 4'b0000;

    // Pointer at 2 with only 0 and 1 requesting wraps to 0, then 1
    ifc.req_valid_i = 4'b0010;
    run_job(1, 3, 0);
    ifc.req_valid_i = 4'b0011;
    run_job(0, 3, 0);
    run_job(1, 3, 0);
    ifc.req_valid_i = 4'b0000;

    // Lock holds off grants; released lock grants 2; consumer stalls 10 cycles
    ifc.lock_i      = 1'b1;
    ifc.req_valid_i = 4'b0100;
    quiet = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ifc.req_ready_o !== '0 || ifc.busy_o !== 1'b0) quiet = 0;
    end
    chk("lock_no_grant", DW'(quiet), 1);
    ifc.lock_i = 1'b0;
    run_job(2, 4, 10);
    ifc.req_valid_i = 4'b0000;

    // Core never answers: abort after 64 wait cycles
    ifc.req_valid_i = 4'b1000;
    core_hang  = 1'b1;
    core_delay = 100;
    #1;
    chk("tmo_ready", DW'(ifc.req_ready_o), DW'(4'b1000));
    step();
    ifc.req_valid_i = 4'b0000;
    chk("tmo_start", DW'(ifc.core_start_o), 1);
    for (int c = 0; c < 64; c++) step();
    chk("tmo_not_early", DW'(ifc.rsp_valid_o), 0);
    step();
    chk("tmo_valid", DW'(ifc.rsp_valid_o), 1);
    chk("tmo_flag", DW'(ifc.rsp_timeout_o), 1);
    chk("tmo_ct_zero", ifc.rsp_ct_o, 0);
    chk("tmo_id", DW'(ifc.rsp_id_o), 3);
    ifc.rsp_ready_i = 1'b1;
    step();
    ifc.rsp_ready_i = 1'b0;
    chk("tmo_idle", DW'(ifc.busy_o), 0);

    // Completion in the final allowed cycle beats the abort
    ifc.req_valid_i = 4'b0001;
    run_job(0, 64, 0);
    ifc.req_valid_i = 4'b0000;

    // Asynchronous reset while waiting for the core
    ifc.req_valid_i = 4'b0010;
    core_delay = 10;
    #1;
    step();
    ifc.req_valid_i = 4'b0000;
    step(); step(); step(); step();
    chk("pre_rst_busy", DW'(ifc.busy_o), 1);
    rst_i = 1'b1;
    #1;
    chk("arst_busy", DW'(ifc.busy_o), 0);
    chk("arst_core_pt", ifc.core_pt_o, 0);
    chk("arst_core_ksel", DW'(ifc.core_ksel_o), 0);
    chk("arst_rsp_valid", DW'(ifc.rsp_valid_o), 0);
    chk("arst_rsp_ct", ifc.rsp_ct_o, 0);
    chk("arst_rsp_id", DW'(ifc.rsp_id_o), 0);
    step();
    rst_i = 1'b0;
    step();
    ifc.req_valid_i = 4'b0100;
    run_job(2, 5, 0);
    ifc.req_valid_i = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
